// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory read-modify-write controller.
package dmem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = WORD_W / NUM_LANES;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRmwWait,
    StWr
  } dmem_state_t;

  // Lane i comes from new_word when be[i] is set, otherwise from old_word.
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0]    old_word,
                                                   input logic [WORD_W-1:0]    new_word,
                                                   input logic [NUM_LANES-1:0] be);
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) begin
        merged[LANE_W*i +: LANE_W] = new_word[LANE_W*i +: LANE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_rmw_ctrl.sv
// Sequences a single-port synchronous data RAM for the CPU data port. The RAM has no
// byte lanes, so partial writes are done as read-modify-write. busy/done handshake to CPU.
module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned RAM_RD_LAT = 1   // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_from_memory,
  input  logic                 write_from_memory,
  input  logic [31:0]          memory_addr,
  input  logic [WORD_W-1:0]    data_to_write,
  input  logic [NUM_LANES-1:0] byte_enable_from_memory,
  output logic [WORD_W-1:0]    data_to_read,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [WORD_W-1:0]    ram_data,
  output logic                 ram_wren,
  input  logic [WORD_W-1:0]    ram_q
);

  // Wait counter reaches this value on the edge where ram_q holds the addressed word.
  localparam logic [1:0] LatCnt = 2'(RAM_RD_LAT);

  dmem_state_t          state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [WORD_W-1:0]    data_to_read_q, data_to_read_d;
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    ram_address_q, ram_address_d;
  logic [WORD_W-1:0]    ram_data_q, ram_data_d;
  logic                 ram_wren_q, ram_wren_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic [NUM_LANES-1:0] be_q, be_d;

  logic [ADDR_W-1:0]    word_idx;
  logic                 unused_addr;

  // Byte address to word index; high bits wrap, low two bits are lane offset only.
  assign word_idx    = memory_addr[ADDR_W+1:2];
  assign unused_addr = ^{memory_addr[31:ADDR_W+2], memory_addr[1:0]};

  // Next-state and registered-output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_to_read_d = data_to_read_q;
    done_d         = 1'b0;
    ram_address_d  = ram_address_q;
    ram_data_d     = ram_data_q;
    ram_wren_d     = 1'b0;
    wdata_d        = wdata_q;
    be_d           = be_q;

    unique case (state_q)
      StIdle: begin
        // A simultaneous read is dropped: write has priority.
        if (write_from_memory) begin
          ram_address_d = word_idx;
          if (byte_enable_from_memory == 4'hF) begin
            ram_data_d = data_to_write;
            ram_wren_d = 1'b1;
            state_d    = StWr;
          end else if (byte_enable_from_memory == 4'h0) begin
            // Nothing to write; complete immediately without touching the RAM.
            done_d = 1'b1;
          end else begin
            wdata_d = data_to_write;
            be_d    = byte_enable_from_memory;
            cnt_d   = 2'd0;
            state_d = StRmwWait;
          end
        end else if (read_from_memory) begin
          ram_address_d = word_idx;
          cnt_d         = 2'd0;
          state_d       = StRdWait;
        end
      end

      StRdWait: begin
        if (cnt_q == LatCnt) begin
          data_to_read_d = ram_q;
          done_d         = 1'b1;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      StRmwWait: begin
        if (cnt_q == LatCnt) begin
          ram_data_d = byte_merge(ram_q, wdata_q, be_q);
          ram_wren_d = 1'b1;
          state_d    = StWr;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      StWr: begin
        // RAM commits the write on this edge; ram_wren falls back to its default 0.
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      cnt_q          <= 2'd0;
      data_to_read_q <= '0;
      done_q         <= 1'b0;
      ram_address_q  <= '0;
      ram_data_q     <= '0;
      ram_wren_q     <= 1'b0;
      wdata_q        <= '0;
      be_q           <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_to_read_q <= data_to_read_d;
      done_q         <= done_d;
      ram_address_q  <= ram_address_d;
      ram_data_q     <= ram_data_d;
      ram_wren_q     <= ram_wren_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign data_to_read = data_to_read_q;
  assign ram_address  = ram_address_q;
  assign ram_data     = ram_data_q;
  assign ram_wren     = ram_wren_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl with a behavioural 1-cycle-latency RAM.
module tb_dmem_rmw_ctrl;

  localparam int unsigned ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_from_memory;
  logic        write_from_memory;
  logic [31:0] memory_addr;
  logic [31:0] data_to_write;
  logic [3:0]  byte_enable_from_memory;
  logic [31:0] data_to_read;
  logic        busy;
  logic        done;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          wr_count   = 0;
  int          done_count = 0;
  int          errors     = 0;
  int          checks     = 0;
  int          wc;
  int          dc;

  always #5 clk = ~clk;

  dmem_rmw_ctrl #(
    .ADDR_W     (ADDR_W),
    .RAM_RD_LAT (1)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .read_from_memory        (read_from_memory),
    .write_from_memory       (write_from_memory),
    .memory_addr             (memory_addr),
    .data_to_write           (data_to_write),
    .byte_enable_from_memory (byte_enable_from_memory),
    .data_to_read            (data_to_read),
    .busy                    (busy),
    .done                    (done),
    .ram_address             (ram_address),
    .ram_data                (ram_data),
    .ram_wren                (ram_wren),
    .ram_q                   (ram_q)
  );

  // Behavioural single-port RAM, read latency 1, read-before-write.
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address] <= ram_data;
      wr_count         <= wr_count + 1;
    end
    ram_q <= mem[ram_address];
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let edge E0 accept it, then scramble inputs to prove latching.
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    read_from_memory        = rd;
    write_from_memory       = wr;
    memory_addr             = addr;
    data_to_write           = data;
    byte_enable_from_memory = be;
    @(posedge clk);
    #1;
    read_from_memory        = 1'b0;
    write_from_memory       = 1'b0;
    memory_addr             = 32'hFFFF_FFFC;
    data_to_write           = 32'hFFFF_FFFF;
    byte_enable_from_memory = 4'hF;
  endtask

  initial begin
    rst                     = 1'b0;
    read_from_memory        = 1'b0;
    write_from_memory       = 1'b0;
    memory_addr             = '0;
    data_to_write           = '0;
    byte_enable_from_memory = '0;
    tick();
    tick();

    // Reset values
    chk("rst_rdata", data_to_read, 32'h0);
    chk("rst_done",  done,         1'b0);
    chk("rst_wren",  ram_wren,     1'b0);
    chk("rst_busy",  busy,         1'b0);
    chk("rst_addr",  32'(ram_address), 32'h0);
    chk("rst_wdata", ram_data,     32'h0);
    rst = 1'b1;
    tick();

    // Full write, done one cycle after acceptance
    req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    chk("fw_addr",  32'(ram_address), 32'h4);
    chk("fw_wren",  ram_wren, 1'b1);
    chk("fw_data",  ram_data, 32'hDEAD_BEEF);
    chk("fw_busy",  busy,     1'b1);
    chk("fw_done0", done,     1'b0);
    tick();
    chk("fw_done",  done,     1'b1);
    chk("fw_wren0", ram_wren, 1'b0);
    chk("fw_busy0", busy,     1'b0);
    chk("fw_mem",   mem[4],   32'hDEAD_BEEF);

    // Read issued back-to-back in the done cycle
    req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd_busy",  busy, 1'b1);
    chk("rd_done0", done, 1'b0);
    tick();
    chk("rd_done1", done, 1'b0);
    tick();
    chk("rd_done",  done, 1'b1);
    chk("rd_data",  data_to_read, 32'hDEAD_BEEF);
    chk("rd_busy0", busy, 1'b0);

    // Partial write via read-modify-write
    req(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'hF);
    tick();
    req(1'b0, 1'b1, 32'h10, 32'h0000_AB00, 4'b0010);
    chk("pw_busy",  busy,     1'b1);
    chk("pw_wren0", ram_wren, 1'b0);
    tick();
    chk("pw_wren1", ram_wren, 1'b0);
    chk("pw_done1", done,     1'b0);
    tick();
    chk("pw_wren2", ram_wren, 1'b1);
    chk("pw_merge", ram_data, 32'h1122_AB44);
    chk("pw_done2", done,     1'b0);
    tick();
    chk("pw_done",  done,     1'b1);
    chk("pw_wren3", ram_wren, 1'b0);
    chk("pw_mem",   mem[4],   32'h1122_AB44);
    chk("pw_rkeep", data_to_read, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    tick();
    chk("pw_rb_done", done, 1'b1);
    chk("pw_rb_data", data_to_read, 32'h1122_AB44);

    // be=0 write: immediate done, no RAM access
    req(1'b0, 1'b1, 32'h20, 32'h0000_0055, 4'hF);
    tick();
    wc = wr_count;
    req(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
    chk("be0_done", done,     1'b1);
    chk("be0_busy", busy,     1'b0);
    chk("be0_wren", ram_wren, 1'b0);
    tick();
    chk("be0_done0", done, 1'b0);
    chk("be0_nowr",  wr_count, wc);
    chk("be0_mem",   mem[8], 32'h0000_0055);

    // Read and write together: write wins, read dropped
    req(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    chk("rw_wren", ram_wren, 1'b1);
    chk("rw_addr", 32'(ram_address), 32'h8);
    chk("rw_data", ram_data, 32'hCAFE_F00D);
    tick();
    chk("rw_done", done, 1'b1);
    chk("rw_mem",  mem[8], 32'hCAFE_F00D);
    tick();
    tick();
    chk("rw_rkeep", data_to_read, 32'h1122_AB44);
    chk("rw_done0", done, 1'b0);

    // Request pulsed while busy is ignored; wrapped address maps to word 8
    dc = done_count;
    wc = wr_count;
    req(1'b0, 1'b1, 32'h0000_4023, 32'h0000_00AA, 4'b0001);
    chk("wrap_addr", 32'(ram_address), 32'h8);
    write_from_memory       = 1'b1;
    memory_addr             = 32'h10;
    data_to_write           = 32'h0;
    byte_enable_from_memory = 4'hF;
    tick();
    write_from_memory = 1'b0;
    tick();
    chk("ign_addr", 32'(ram_address), 32'h8);
    tick();
    tick();
    tick();
    chk("ign_dones",  32'(done_count - dc), 32'd1);
    chk("ign_writes", 32'(wr_count - wc),   32'd1);
    chk("ign_mem8",   mem[8], 32'hCAFE_F0AA);
    chk("ign_mem4",   mem[4], 32'h1122_AB44);

    // Reset during RMW_WAIT aborts the write
    wc = wr_count;
    req(1'b0, 1'b1, 32'h10, 32'h7700_0000, 4'b1000);
    chk("ab_busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ab_rdata", data_to_read, 32'h0);
    chk("ab_done",  done,         1'b0);
    chk("ab_wren",  ram_wren,     1'b0);
    chk("ab_busy0", busy,         1'b0);
    repeat (3) tick();
    chk("ab_nowr", wr_count, wc);
    chk("ab_mem",  mem[4],   32'h1122_AB44);
    rst = 1'b1;
    tick();
    req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    tick();
    chk("ab_rd_done", done, 1'b1);
    chk("ab_rd_data", data_to_read, 32'h1122_AB44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
